// File: rtl/divu8_seq_if.sv
// divu8_seq_if: operand and result valid/ready bundle
// for the sequential 8-bit unsigned divider.
interface divu8_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       div_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quot, rem, div_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quot, rem, div_zero
  );
endinterface

// File: rtl/divu8_seq.sv
// divu8_seq: restoring unsigned 8-bit divider, one step per clock.
// Define DIVU8_REM_EN to drive the remainder output; otherwise rem is 0.
module divu8_seq (
  input  logic       clk,
  input  logic       rst,
  divu8_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;
  logic [7:0] q_q, q_d;
  logic [7:0] b_q, b_d;
  logic [7:0] quot_q, quot_d;
  logic       dz_q, dz_d;
`ifdef DIVU8_REM_EN
  logic [7:0] rem_q, rem_d;
`endif

  logic [8:0] p_sh;
  logic [8:0] p_sub;
  logic [7:0] q_nx;
  logic       ge;

  // P < b after every step, so the stored partial remainder fits in 8 bits.
  // p_sh < 2b, hence the borrow bit of the 9-bit difference decides P >= b.
  always_comb begin
    p_sh  = {p_q, q_q[7]};
    p_sub = p_sh - {1'b0, b_q};
    ge    = ~p_sub[8];
    q_nx  = {q_q[6:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    b_d     = b_q;
    quot_d  = quot_q;
    dz_d    = dz_q;
`ifdef DIVU8_REM_EN
    rem_d   = rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          b_d     = bus.b;
          q_d     = bus.a;
          p_d     = 8'd0;
          cnt_d   = 3'd7;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_q == 8'd0) begin
          quot_d  = 8'hFF;
          dz_d    = 1'b1;
`ifdef DIVU8_REM_EN
          rem_d   = q_q;
`endif
          state_d = DONE;
        end else begin
          p_d = ge ? p_sub[7:0] : p_sh[7:0];
          q_d = q_nx;
          if (cnt_q == 3'd0) begin
            quot_d  = q_nx;
            dz_d    = 1'b0;
`ifdef DIVU8_REM_EN
            rem_d   = ge ? p_sub[7:0] : p_sh[7:0];
`endif
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      p_q     <= 8'd0;
      q_q     <= 8'd0;
      b_q     <= 8'd0;
      quot_q  <= 8'd0;
      dz_q    <= 1'b0;
`ifdef DIVU8_REM_EN
      rem_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      dz_q    <= dz_d;
`ifdef DIVU8_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quot      = quot_q;
  assign bus.div_zero  = dz_q;
`ifdef DIVU8_REM_EN
  assign bus.rem       = rem_q;
`else
  assign bus.rem       = 8'd0;
`endif
endmodule

// File: tb/tb_divu8_seq.sv
// tb_divu8_seq: directed and swept checks of divu8_seq
// (rem expectations follow DIVU8_REM_EN).
module tb_divu8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  divu8_seq_if io ();

  divu8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rem_exp(input logic [7:0] r);
`ifdef DIVU8_REM_EN
    return r;
`else
    return 8'd0;
`endif
  endfunction

  // hold >= 0: cycles out_ready stays low once valid; hold < 0: random
  task automatic op(input logic [7:0] va, input logic [7:0] vb,
                    input logic [7:0] eq, input logic [7:0] er,
                    input logic ed, input int hold,
                    input bit tog, input string tag);
    int         lat;
    int         waitc;
    bit         irdy_bad;
    bit         unstable;
    logic [7:0] q0;
    logic [7:0] r0;
    logic       d0;
    lat      = 0;
    irdy_bad = 1'b0;
    unstable = 1'b0;
    waitc    = (hold >= 0) ? hold : int'($urandom_range(0, 3));
    chk({tag, ".idle"}, 32'(io.in_ready), 32'd1);
    io.a         = va;
    io.b         = vb;
    io.in_valid  = 1'b1;
    io.out_ready = (waitc == 0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    while (!io.out_valid && lat < 20) begin
      if (io.in_ready) irdy_bad = 1'b1;
      if (tog) begin
        io.a        = 8'($urandom);
        io.b        = 8'($urandom);
        io.in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), (vb == 8'd0) ? 32'd1 : 32'd8);
    chk({tag, ".irdy_busy"}, 32'(irdy_bad | io.in_ready), 32'd0);
    chk({tag, ".quot"}, 32'(io.quot), 32'(eq));
    chk({tag, ".rem"}, 32'(io.rem), 32'(rem_exp(er)));
    chk({tag, ".dz"}, 32'(io.div_zero), 32'(ed));
    q0 = io.quot;
    r0 = io.rem;
    d0 = io.div_zero;
    repeat (waitc) begin
      io.out_ready = 1'b0;
      if (tog) begin
        io.a        = 8'($urandom);
        io.b        = 8'($urandom);
        io.in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (!io.out_valid || io.in_ready || io.quot !== q0 ||
          io.rem !== r0 || io.div_zero !== d0)
        unstable = 1'b1;
    end
    chk({tag, ".hold"}, 32'(unstable), 32'd0);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".ov_drop"}, 32'(io.out_valid), 32'd0);
    chk({tag, ".irdy_back"}, 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    io.a         = 8'd0;
    io.b         = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.quot", 32'(io.quot), 32'd0);
    chk("rst.rem", 32'(io.rem), 32'd0);
    chk("rst.dz", 32'(io.div_zero), 32'd0);
    chk("rst.ov", 32'(io.out_valid), 32'd0);
    chk("rst.irdy", 32'(io.in_ready), 32'd1);
    rst = 1'b0;

    op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 0, 1'b0, "d200_7");
    op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0, 1'b0, "d255_1");
    op(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 0, 1'b0, "d3_10");
    op(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 3, 1'b1, "hold77_5");
    op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0, 1'b0, "d5_0");

    io.a        = 8'd100;
    io.b        = 8'd3;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.quot", 32'(io.quot), 32'd0);
    chk("midrst.rem", 32'(io.rem), 32'd0);
    chk("midrst.dz", 32'(io.div_zero), 32'd0);
    chk("midrst.ov", 32'(io.out_valid), 32'd0);
    chk("midrst.irdy", 32'(io.in_ready), 32'd1);
    op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 0, 1'b0, "d100_3");

    for (int ia = 0; ia <= 255; ia += 51) begin
      for (int ib = 0; ib < 256; ib++) begin
        op(8'(ia), 8'(ib),
           (ib == 0) ? 8'hFF : 8'(ia / ib),
           (ib == 0) ? 8'(ia) : 8'(ia % ib),
           (ib == 0), -1, 1'b0,
           $sformatf("sw a=%0d b=%0d", ia, ib));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
